// File: rtl/mod13_pkg.sv
// Shared types and constants for the mod-13 sequence monitor.
package mod13_pkg;

    // Terminal count of the monitored upstream counter (counts 0..12).
    localparam logic [3:0] MOD13_MAX = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SYNC  = 2'b01,
        ST_LOCK  = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_SKIP  = 2'b10
    } err_code_e;

    // Successor of q in a counter that wraps from max_q back to 0.
    function automatic logic [3:0] mod_next(input logic [3:0] q, input logic [3:0] max_q);
        return (q == max_q) ? 4'd0 : q + 4'd1;
    endfunction

endpackage

// File: rtl/mod13_seq_monitor_sat_counter.sv
// Saturating up-counter with a sticky "reached all-ones" flag.
// clr has priority over inc; the count never wraps back to zero.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_sat;

    // Count events, stop at all-ones and latch the saturation flag on that same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (inc && (r_count != ALL_ONES)) begin
            r_count <= r_count + ONE;
            if (r_count == (ALL_ONES - ONE)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign count = r_count;
    assign sat   = r_sat;

endmodule

// File: rtl/mod13_seq_monitor.sv
// Monitors a sampled mod-13 count stream: locks onto it, flags wraps and
// illegal steps, and keeps saturating tallies of both.
module mod13_seq_monitor
    import mod13_pkg::*;
#(
    parameter int         WRAP_W = 8,
    parameter logic [3:0] MAX_Q  = MOD13_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr_stats,
    input  logic [3:0]        q_in,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              wrap_sat,
    output logic              err_pulse,
    output logic [1:0]        err_code,
    output logic [3:0]        err_count
);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_prev_q;
    logic       r_wrap_pulse;
    logic       r_err_pulse;
    err_code_e  r_err_code;

    logic       w_range;
    logic       w_legal;
    logic       w_wrap;
    logic       w_err;
    err_code_e  w_err_kind;
    logic       w_err_sat;

    assign w_range = (q_in > MAX_Q);
    assign w_legal = (q_in == r_prev_q) || (q_in == mod_next(r_prev_q, MAX_Q));

    // State register; reset aborts any tracking and restarts from IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the single-cycle wrap/error events it produces.
    always_comb begin
        w_state_nxt = r_state;
        w_wrap      = 1'b0;
        w_err       = 1'b0;
        w_err_kind  = ERR_NONE;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_SYNC;
                ST_SYNC: begin
                    if (!w_range) begin
                        w_state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Out-of-range is reported even when it is also a skip.
                    if (w_range) begin
                        w_state_nxt = ST_FAULT;
                        w_err       = 1'b1;
                        w_err_kind  = ERR_RANGE;
                    end else if (!w_legal) begin
                        w_state_nxt = ST_FAULT;
                        w_err       = 1'b1;
                        w_err_kind  = ERR_SKIP;
                    end else if ((r_prev_q == MAX_Q) && (q_in == 4'd0)) begin
                        w_wrap = 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (q_in == 4'd0) begin
                        w_state_nxt = ST_LOCK;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sample history, registered pulses and the held error code (clear beats a new error).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_q     <= 4'd0;
            r_wrap_pulse <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_prev_q     <= q_in;
            r_wrap_pulse <= w_wrap;
            r_err_pulse  <= w_err;
            if (clr_stats) begin
                r_err_code <= ERR_NONE;
            end else if (w_err) begin
                r_err_code <= w_err_kind;
            end
        end
    end

    sat_counter #(
        .WIDTH (WRAP_W)
    ) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_wrap),
        .clr   (clr_stats),
        .count (wrap_count),
        .sat   (wrap_sat)
    );

    // Once the error tally is pinned at 15, further errors are not presented to it.
    sat_counter #(
        .WIDTH (4)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_err & ~w_err_sat),
        .clr   (clr_stats),
        .count (err_count),
        .sat   (w_err_sat)
    );

    assign locked     = (r_state == ST_LOCK);
    assign wrap_pulse = r_wrap_pulse;
    assign err_pulse  = r_err_pulse;
    assign err_code   = r_err_code;

endmodule

// File: tb/tb_mod13_seq_monitor.sv
// Directed bench for mod13_seq_monitor with a cycle-level reference model.
module tb_mod13_seq_monitor;

    localparam int WW   = 2;
    localparam int WMAX = (1 << WW) - 1;
    localparam int QMAX = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic          clr_stats = 1'b0;
    logic [3:0]    q_in = 4'd0;
    logic          locked;
    logic          wrap_pulse;
    logic [WW-1:0] wrap_count;
    logic          wrap_sat;
    logic          err_pulse;
    logic [1:0]    err_code;
    logic [3:0]    err_count;

    mod13_seq_monitor #(.WRAP_W(WW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr_stats  (clr_stats),
        .q_in       (q_in),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count),
        .wrap_sat   (wrap_sat),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Reference model: phase 0 disabled, 1 waiting for an in-range sample,
    // 2 following the count, 3 waiting for a 0 after a broken sequence.
    int m_phase = 0;
    int m_prev  = 0;
    int m_wc    = 0;
    int m_ec    = 0;
    int m_code  = 0;
    bit m_ws    = 1'b0;
    bit m_wrap  = 1'b0;
    bit m_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void model_step(input bit r, input bit e, input bit c, input int q);
        int code;
        if (!r) begin
            m_phase = 0; m_prev = 0; m_wc = 0; m_ec = 0; m_code = 0;
            m_ws = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
            return;
        end
        m_wrap = 1'b0;
        m_err  = 1'b0;
        code   = 0;
        if (!e) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (q <= QMAX) m_phase = 2;
        end else if (m_phase == 2) begin
            if (q > QMAX) begin
                m_err = 1'b1; code = 1; m_phase = 3;
            end else if (q != m_prev && q != (m_prev + 1) % (QMAX + 1)) begin
                m_err = 1'b1; code = 2; m_phase = 3;
            end else if (m_prev == QMAX && q == 0) begin
                m_wrap = 1'b1;
            end
        end else begin
            if (q == 0) m_phase = 2;
        end
        if (c) begin
            m_wc = 0; m_ws = 1'b0; m_ec = 0; m_code = 0;
        end else begin
            if (m_wrap && m_wc < WMAX) m_wc++;
            if (m_wc == WMAX) m_ws = 1'b1;
            if (m_err) begin
                if (m_ec < 15) m_ec++;
                m_code = code;
            end
        end
        m_prev = q;
    endfunction

    // Compare every output against the model just after each active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("locked",     32'(locked),     32'(m_phase == 2));
            check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
            check("wrap_count", 32'(wrap_count), 32'(m_wc));
            check("wrap_sat",   32'(wrap_sat),   32'(m_ws));
            check("err_pulse",  32'(err_pulse),  32'(m_err));
            check("err_code",   32'(err_code),   32'(m_code));
            check("err_count",  32'(err_count),  32'(m_ec));
        end
    end

    task automatic cycle(input bit r, input bit e, input bit c, input int q);
        @(negedge clk);
        reset     = r;
        en        = e;
        clr_stats = c;
        q_in      = 4'(q);
        model_step(r, e, c, q);
        chk_en = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic run(input int q);
        cycle(1'b1, 1'b1, 1'b0, q);
    endtask

    initial begin
        // Reset overrides en and clr_stats.
        cycle(1'b0, 1'b1, 1'b1, 0);
        cycle(1'b0, 1'b1, 1'b1, 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_wrap_count", 32'(wrap_count), 0);
        check("rst_err_code", 32'(err_code), 0);

        // Full count 0..12,0 after reset.
        run(0);
        check("seq_c1_locked", 32'(locked), 0);
        run(1);
        check("seq_c2_locked", 32'(locked), 1);
        for (int i = 2; i <= 12; i++) run(i);
        run(0);
        check("seq_wrap_pulse", 32'(wrap_pulse), 1);
        check("seq_wrap_count", 32'(wrap_count), 1);
        run(0);
        check("seq_hold_no_pulse", 32'(wrap_pulse), 0);

        // Skip error 5 -> 7, recovery on 0.
        for (int i = 1; i <= 5; i++) run(i);
        run(5);
        run(7);
        check("skip_err_pulse", 32'(err_pulse), 1);
        check("skip_err_code", 32'(err_code), 2);
        check("skip_err_count", 32'(err_count), 1);
        check("skip_locked", 32'(locked), 0);
        run(0);
        check("skip_relock", 32'(locked), 1);

        // Range error wins over skip; no second pulse while faulted.
        run(1);
        run(2);
        run(14);
        check("range_err_code", 32'(err_code), 1);
        check("range_locked", 32'(locked), 0);
        run(3);
        check("fault_no_pulse", 32'(err_pulse), 0);
        check("fault_err_count", 32'(err_count), 2);
        run(0);
        check("range_relock", 32'(locked), 1);

        // Clear statistics without disturbing lock.
        cycle(1'b1, 1'b1, 1'b1, 0);
        check("clr_wrap_count", 32'(wrap_count), 0);
        check("clr_err_count", 32'(err_count), 0);
        check("clr_locked", 32'(locked), 1);

        // Four wraps with a 2-bit tally.
        for (int s = 0; s < 4; s++) begin
            for (int i = 1; i <= 12; i++) run(i);
            run(0);
            if (s == 1) check("wsat_after2", 32'(wrap_sat), 0);
            if (s == 2) begin
                check("wcnt_after3", 32'(wrap_count), 3);
                check("wsat_after3", 32'(wrap_sat), 1);
            end
        end
        check("wcnt_after4", 32'(wrap_count), 3);
        check("wpulse_after4", 32'(wrap_pulse), 1);

        // Clear coincident with a wrap.
        run(1);
        run(3);
        run(0);
        for (int i = 1; i <= 12; i++) run(i);
        cycle(1'b1, 1'b1, 1'b1, 0);
        check("clrwrap_pulse", 32'(wrap_pulse), 1);
        check("clrwrap_count", 32'(wrap_count), 0);
        check("clrwrap_sat", 32'(wrap_sat), 0);
        check("clrwrap_code", 32'(err_code), 0);

        // Disable on an illegal step, then re-acquire through SYNC.
        run(1);
        run(2);
        cycle(1'b1, 1'b0, 1'b0, 9);
        check("dis_locked", 32'(locked), 0);
        check("dis_no_err", 32'(err_pulse), 0);
        run(14);
        run(14);
        check("sync_oor_locked", 32'(locked), 0);
        check("sync_oor_no_err", 32'(err_pulse), 0);
        run(0);
        check("sync_relock", 32'(locked), 1);

        // Error tally saturates at 15.
        for (int k = 0; k < 17; k++) begin
            run(0);
            run(2);
        end
        check("ecnt_sat", 32'(err_count), 15);

        // Reset while tracking at 7.
        run(0);
        for (int i = 1; i <= 7; i++) run(i);
        check("pre_rst_locked", 32'(locked), 1);
        cycle(1'b0, 1'b1, 1'b0, 7);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_err_count", 32'(err_count), 0);
        check("midrst_err_code", 32'(err_code), 0);
        run(7);
        check("rel_c1_locked", 32'(locked), 0);
        run(7);
        check("rel_c2_locked", 32'(locked), 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
